loader_write_sink: RTL and testbench

Downstream stage of the loader address remapper: captures each bridge write that the remapper flags as selected, together with its mapped address and 32-bit data, into a small FIFO. It then serialises each 32-bit word into DATA_WIDTH-bit beats on a valid/ready memory-write stream, incrementing the address per beat. Bridge writes cannot be stalled, so the FIFO absorbs bursts; any loss is reported through a sticky overflow flag.

---
 rtl/loader_pkg.sv | 29 ++
 rtl/loader_fifo.sv | 68 ++++++
 rtl/loader_write_sink.sv | 168 ++++++++++++++++
 tb/tb_loader_write_sink.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and helpers for the loader write sink.
// Optional build macro used by the design: LOADER_LITTLE_ENDIAN_EN.
package loader_pkg;

    // One captured bridge write: mapped byte address plus 32-bit data.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } write_entry_t;

    localparam int ENTRY_WIDTH = $bits(write_entry_t);

    // Serialiser states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sink_state_t;

    // Number of beats needed to move one 32-bit word.
    function automatic int beats_for_width(input int width);
        return 32 / width;
    endfunction

    // Only 8, 16 and 32 divide a word into whole bytes per beat.
    function automatic bit width_is_legal(input int width);
        return (width == 8) || (width == 16) || (width == 32);
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: synchronous FIFO, generic width/depth, no output register.
// A push while full is accepted only when a pop happens in the same cycle.
// Full/empty are registered from the next-state pointers.
module loader_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("loader_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next pointers and the registered full/empty they imply.
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q + (AW + 1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(do_pop);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/loader_write_sink.sv
// loader_write_sink: buffers selected bridge writes and serialises each
// 32-bit word into DATA_WIDTH-bit beats on a valid/ready write stream.
// Build macro LOADER_LITTLE_ENDIAN_EN: emit the least-significant sub-word
// first (addresses still ascend); no effect when DATA_WIDTH = 32.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no word in flight; load the FIFO head as soon as one exists
// ST_SHIFT | a beat is presented; advance on handshake, chain next word
module loader_write_sink
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  wr_selected,
    input  logic [31:0]           wr_address,
    input  logic [31:0]           wr_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [31:0]           mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  overflow_clear
);

    if (!width_is_legal(DATA_WIDTH)) begin : g_bad_width
        $error("loader_write_sink: DATA_WIDTH must be 8, 16 or 32");
    end

    localparam int BEATS = beats_for_width(DATA_WIDTH);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    sink_state_t  state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [31:0]  shift_q, shift_d;
    logic [31:0]  addr_q, addr_d;
    logic         valid_q, valid_d;
    logic         overflow_q, overflow_d;

    write_entry_t push_entry;
    write_entry_t head;
    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic         load;
    logic         drop;
    logic [31:0]  shift_adv;

    assign fifo_push  = wr && wr_selected;
    assign push_entry = '{addr: wr_address, data: wr_data};

    loader_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The presented beat always sits at one end of the shift register;
    // advancing moves the next sub-word into that position.
    if (DATA_WIDTH == 32) begin : g_no_shift
        assign shift_adv = shift_q;
        assign mem_data  = shift_q;
    end else begin : g_shift
`ifdef LOADER_LITTLE_ENDIAN_EN
        assign shift_adv = {{DATA_WIDTH{1'b0}}, shift_q[31:DATA_WIDTH]};
        assign mem_data  = shift_q[DATA_WIDTH-1:0];
`else
        assign shift_adv = {shift_q[31-DATA_WIDTH:0], {DATA_WIDTH{1'b0}}};
        assign mem_data  = shift_q[31 -: DATA_WIDTH];
`endif
    end

    // Serialiser next-state, FIFO pop and sticky overflow.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        shift_d  = shift_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        fifo_pop = 1'b0;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (valid_q && mem_ready) begin
                    if (beat_q != BEAT_LAST) begin
                        shift_d = shift_adv;
                        addr_d  = addr_q + 32'(BYTES);
                        beat_d  = beat_q + 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Loading from either state pops the head with no bubble.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = head.data;
            addr_d   = head.addr;
            beat_d   = '0;
            valid_d  = 1'b1;
            state_d  = ST_SHIFT;
        end

        // A write that finds the FIFO full with no pop is lost; setting
        // takes priority over a clear in the same cycle.
        drop = fifo_push && fifo_full && !fifo_pop;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Serialiser and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign mem_valid   = valid_q;
    assign mem_address = addr_q;
    assign overflow    = overflow_q;
    assign busy        = !fifo_empty || (state_q == ST_SHIFT);

endmodule

// File: tb/tb_loader_write_sink.sv
// Bench for loader_write_sink: one 8-bit and one 16-bit instance, a
// scoreboard of expected beats per instance, directed steps.
// Honours LOADER_LITTLE_ENDIAN_EN for the expected beat order.
module tb_loader_write_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr8, wr16, sel, oclr;
    logic [31:0] waddr, wdata;
    logic        r8, r16;
    logic        v8, v16, busy8, busy16, ov8, ov16;
    logic [31:0] a8, a16;
    logic [7:0]  d8;
    logic [15:0] d16;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] q8[$];
    logic [63:0] q16[$];
    bit          held8, held16;
    logic [63:0] hb8, hb16;

    always #5 clk = ~clk;

    loader_write_sink #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut8 (
        .clk(clk), .reset(reset), .wr(wr8), .wr_selected(sel),
        .wr_address(waddr), .wr_data(wdata), .mem_valid(v8),
        .mem_ready(r8), .mem_address(a8), .mem_data(d8), .busy(busy8),
        .overflow(ov8), .overflow_clear(oclr)
    );

    loader_write_sink #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) u_dut16 (
        .clk(clk), .reset(reset), .wr(wr16), .wr_selected(sel),
        .wr_address(waddr), .wr_data(wdata), .mem_valid(v16),
        .mem_ready(r16), .mem_address(a16), .mem_data(d16), .busy(busy16),
        .overflow(ov16), .overflow_clear(oclr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected beats for one accepted word, pushed at write time.
    task automatic expect_word(input int which, input logic [31:0] addr, input logic [31:0] data);
        int          w;
        int          nb;
        logic [31:0] sub;
        logic [31:0] mask;
        w    = (which == 0) ? 8 : 16;
        nb   = 32 / w;
        mask = (which == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
        for (int b = 0; b < nb; b++) begin
`ifdef LOADER_LITTLE_ENDIAN_EN
            sub = (data >> (b * w)) & mask;
`else
            sub = (data >> (32 - (b + 1) * w)) & mask;
`endif
            if (which == 0) q8.push_back({addr + 32'(b * w / 8), sub});
            else            q16.push_back({addr + 32'(b * w / 8), sub});
        end
    endtask

    // Per-instance stream monitor, sampled at the falling edge.
    task automatic mon(input int which, input logic v, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
        bit          h;
        logic [63:0] hb;
        logic [63:0] obs;
        logic [63:0] expv;
        int          sz;
        obs = {a, d};
        if (which == 0) begin h = held8;  hb = hb8;  sz = q8.size();  end
        else            begin h = held16; hb = hb16; sz = q16.size(); end
        if (h) begin
            chk($sformatf("dut%0d_hold_valid", which), {63'd0, v}, 64'd1);
            chk($sformatf("dut%0d_hold_beat", which), obs, hb);
        end
        h  = v && !r;
        hb = obs;
        if (v && r) begin
            n_vec++;
            assert (sz != 0) else begin
                n_err++;
                $error("FAIL dut%0d_spurious_beat: observed %h expected no beat", which, obs);
            end
            if (sz != 0) begin
                expv = (which == 0) ? q8.pop_front() : q16.pop_front();
                chk($sformatf("dut%0d_beat", which), obs, expv);
            end
        end
        if (which == 0) begin held8 = h;  hb8 = hb;  end
        else            begin held16 = h; hb16 = hb; end
    endtask

    task automatic step();
        @(negedge clk);
        mon(0, v8, r8, a8, {24'd0, d8});
        mon(1, v16, r16, a16, {16'd0, d16});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        held8 = 1'b0;
        held16 = 1'b0;
        q8.delete();
        q16.delete();
    endtask

    task automatic write8(input logic [31:0] addr, input logic [31:0] data,
                          input logic s, input bit accepted);
        wr8 = 1'b1; sel = s; waddr = addr; wdata = data;
        if (accepted) expect_word(0, addr, data);
        step();
        wr8 = 1'b0; sel = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr8 = 1'b0; wr16 = 1'b0; sel = 1'b0; oclr = 1'b0;
        waddr = '0; wdata = '0; r8 = 1'b0; r16 = 1'b0;
        clear_sb();
        step();
        step();
        chk("reset_valid", {63'd0, v8}, 64'd0);
        chk("reset_busy", {63'd0, busy8}, 64'd0);
        chk("reset_overflow", {63'd0, ov8}, 64'd0);
        chk("reset_addr", {32'd0, a8}, 64'd0);
        chk("reset_data", {56'd0, d8}, 64'd0);
        reset = 1'b0;
        step();

        // Width 8, ready high: latency and four consecutive beats.
        r8 = 1'b1;
        write8(32'h0000_1000, 32'hAABB_CCDD, 1'b1, 1'b1);
        chk("lat_valid_low", {63'd0, v8}, 64'd0);
        chk("lat_busy", {63'd0, busy8}, 64'd1);
        step();
        chk("lat_valid_high", {63'd0, v8}, 64'd1);
        chk("lat_addr", {32'd0, a8}, 64'h1000);
        repeat (4) step();
        chk("w8_drained", 64'(q8.size()), 64'd0);
        chk("w8_idle_valid", {63'd0, v8}, 64'd0);
        chk("w8_idle_busy", {63'd0, busy8}, 64'd0);

        // Width 16 with ready toggling every cycle.
        wr16 = 1'b1; sel = 1'b1; waddr = 32'h20; wdata = 32'h1234_5678;
        expect_word(1, 32'h20, 32'h1234_5678);
        r16 = 1'b1;
        step();
        wr16 = 1'b0; sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            r16 = ~r16;
            step();
        end
        chk("w16_drained", 64'(q16.size()), 64'd0);
        chk("w16_idle_valid", {63'd0, v16}, 64'd0);

        // Address wrap across 2^32.
        write8(32'hFFFF_FFFE, 32'h0102_0304, 1'b1, 1'b1);
        repeat (6) step();
        chk("wrap_drained", 64'(q8.size()), 64'd0);

        // Unselected write produces nothing.
        write8(32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("unsel_busy0", {63'd0, busy8}, 64'd0);
        step();
        chk("unsel_busy1", {63'd0, busy8}, 64'd0);
        chk("unsel_valid", {63'd0, v8}, 64'd0);

        // A write every BEATS cycles keeps up without loss.
        for (int k = 0; k < 3; k++) begin
            write8(32'h0000_0300 + 32'(k * 4), 32'h5A00_00A5 + 32'(k), 1'b1, 1'b1);
            repeat (3) step();
        end
        repeat (6) step();
        chk("rate_overflow", {63'd0, ov8}, 64'd0);
        chk("rate_drained", 64'(q8.size()), 64'd0);

        // Overflow: ready low, six writes, sixth is lost.
        r8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write8(32'h0000_0100 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1), 1'b1, i < 5);
            if (i == 4) chk("ovf_before", {63'd0, ov8}, 64'd0);
        end
        chk("ovf_set", {63'd0, ov8}, 64'd1);
        chk("ovf_busy", {63'd0, busy8}, 64'd1);
        oclr = 1'b1;
        step();
        oclr = 1'b0;
        chk("ovf_cleared", {63'd0, ov8}, 64'd0);
        chk("ovf_clr_busy", {63'd0, busy8}, 64'd1);
        oclr = 1'b1;
        write8(32'h0000_0900, 32'hFFFF_0000, 1'b1, 1'b0);
        oclr = 1'b0;
        chk("ovf_set_wins", {63'd0, ov8}, 64'd1);
        oclr = 1'b1;
        step();
        oclr = 1'b0;
        r8 = 1'b1;
        repeat (20) step();
        chk("ovf_drain_b2b", 64'(q8.size()), 64'd0);
        chk("ovf_drain_valid", {63'd0, v8}, 64'd0);
        chk("ovf_drain_busy", {63'd0, busy8}, 64'd0);

        // Reset with the second beat of a word pending and a full FIFO.
        r8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write8(32'h0000_0500 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1, i < 5);
        end
        chk("pre_rst_ovf", {63'd0, ov8}, 64'd1);
        r8 = 1'b1;
        step();
        r8 = 1'b0;
        step();
        chk("pre_rst_valid", {63'd0, v8}, 64'd1);
        chk("pre_rst_addr", {32'd0, a8}, 64'h0501);
        reset = 1'b1;
        #1;
        chk("rst_valid", {63'd0, v8}, 64'd0);
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_overflow", {63'd0, ov8}, 64'd0);
        clear_sb();
        step();
        step();
        reset = 1'b0;
        r8 = 1'b1;
        repeat (12) step();
        chk("post_rst_valid", {63'd0, v8}, 64'd0);
        chk("post_rst_busy", {63'd0, busy8}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
